// File: rtl/fb_pkg.sv
// Shared defaults, state encoding and sizing helper for the framebuffer scanout arbiter.
package fb_pkg;

    localparam int unsigned H_ACTIVE_DEF   = 640;
    localparam int unsigned V_ACTIVE_DEF   = 480;
    localparam int unsigned V_TOTAL_DEF    = 525;
    localparam int unsigned PIX_W_DEF      = 8;
    localparam int unsigned ADDR_W_DEF     = 19;
    localparam int unsigned FIFO_DEPTH_DEF = 4;
    localparam int unsigned LOW_WATER_DEF  = 2;
    localparam int unsigned Y_W            = 10;
    localparam int unsigned UF_CNT_W       = 16;

    typedef enum logic [1:0] {
        StResync = 2'd0,
        StFetch  = 2'd1,
        StDone   = 2'd2
    } fb_state_e;

    // Occupancy counter width able to hold 0..depth inclusive.
    function automatic int unsigned fb_cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fb_scanout_arbiter_if.sv
// GPU write handshake plus single-port framebuffer RAM bus; master = arbiter, slave = GPU/RAM side.
interface fb_scanout_arbiter_if import fb_pkg::*; #(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned PIX_W  = PIX_W_DEF
) ();

    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [PIX_W-1:0]  wr_data;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [PIX_W-1:0]  mem_wdata;
    logic [PIX_W-1:0]  mem_rdata;

    modport master (
        input  wr_valid, wr_addr, wr_data, mem_rdata,
        output wr_ready, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output wr_valid, wr_addr, wr_data, mem_rdata,
        input  wr_ready, mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/fb_sync_fifo.sv
// Synchronous FIFO with flush and occupancy count; head is registered storage, no fall-through.
module fb_sync_fifo import fb_pkg::*; #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CntW = fb_cnt_w(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CntW-1:0]  count_o,
    output logic             empty_o,
    output logic             full_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // A full FIFO may still accept a push when the same cycle frees a slot.
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/fb_scanout_arbiter.sv
// Shares one framebuffer RAM between VGA scanout prefetch and GPU writes.
// Optional FB_UNDERFLOW_CNT_EN adds a saturating count of starved visible pixels.
module fb_scanout_arbiter import fb_pkg::*; #(
    parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
    parameter int unsigned V_TOTAL    = V_TOTAL_DEF,
    parameter int unsigned PIX_W      = PIX_W_DEF,
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int unsigned LOW_WATER  = LOW_WATER_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pix_en,
    input  logic [Y_W-1:0]      y,
    input  logic                blank,
    output logic [PIX_W-1:0]    pix_out,
    output logic                underflow,
    output logic [UF_CNT_W-1:0] underflow_cnt,
    fb_scanout_arbiter_if.master bus_io
);

    localparam int unsigned CntW = fb_cnt_w(FIFO_DEPTH);
    localparam int unsigned ResW = CntW + 1;

    localparam logic [ResW-1:0]   DepthRes    = ResW'(FIFO_DEPTH);
    localparam logic [ResW-1:0]   LowWaterRes = ResW'(LOW_WATER);
    localparam logic [ADDR_W-1:0] LastAddr    = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
    localparam logic [Y_W-1:0]    PrefillLine = Y_W'(V_TOTAL - 1);
    localparam logic [Y_W-1:0]    VisEnd      = Y_W'(V_ACTIVE);

    fb_state_e         state_q;
    logic [ADDR_W-1:0] fetch_addr_q;
    logic              inflight_q;
    logic [PIX_W-1:0]  pix_out_q;
    logic              underflow_q;

    logic [CntW-1:0]   fifo_count;
    logic              fifo_empty;
    logic              fifo_full;
    logic [PIX_W-1:0]  fifo_head;
    logic              fifo_flush;
    logic              fifo_pop;

    logic [ResW-1:0]   reserved;
    logic              fetch_ok;
    logic              urgent;
    logic              wr_go;
    logic              rd_go;
    logic              pix_vis;
    logic              pix_starve;

    // Reads in flight count against FIFO space so a returning word always has a slot.
    assign reserved = ResW'(fifo_count) + ResW'(inflight_q);

    always_comb begin
        fetch_ok   = (state_q == StFetch) && (reserved < DepthRes);
        urgent     = fetch_ok && (reserved < LowWaterRes);
        wr_go      = bus_io.wr_valid && !urgent;
        rd_go      = fetch_ok && !wr_go;
        pix_vis    = pix_en && !blank;
        fifo_pop   = pix_vis && !fifo_empty;
        pix_starve = pix_vis && fifo_empty;
        fifo_flush = (state_q == StResync);
    end

    assign bus_io.wr_ready  = !urgent;
    assign bus_io.mem_en    = wr_go || rd_go;
    assign bus_io.mem_we    = wr_go;
    assign bus_io.mem_addr  = wr_go ? bus_io.wr_addr : fetch_addr_q;
    assign bus_io.mem_wdata = bus_io.wr_data;

    fb_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PIX_W)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (reset),
        .flush_i (fifo_flush),
        .push_i  (inflight_q),
        .pop_i   (fifo_pop),
        .wdata_i (bus_io.mem_rdata),
        .rdata_o (fifo_head),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StResync;
            fetch_addr_q <= '0;
            inflight_q   <= 1'b0;
            pix_out_q    <= '0;
            underflow_q  <= 1'b0;
        end else begin
            inflight_q <= rd_go;

            unique case (state_q)
                StResync: begin
                    fetch_addr_q <= '0;
                    if (y == PrefillLine) begin
                        state_q <= StFetch;
                    end
                end
                StFetch: begin
                    if (rd_go) begin
                        fetch_addr_q <= fetch_addr_q + 1'b1;
                        if (fetch_addr_q == LastAddr) begin
                            state_q <= StDone;
                        end
                    end
                end
                StDone: begin
                    if ((y >= VisEnd) && (y != PrefillLine)) begin
                        state_q <= StResync;
                    end
                end
                default: state_q <= StResync;
            endcase

            if (pix_en) begin
                pix_out_q <= fifo_pop ? fifo_head : '0;
            end
            if (pix_starve) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign pix_out   = pix_out_q;
    assign underflow = underflow_q;

`ifdef FB_UNDERFLOW_CNT_EN
    logic [UF_CNT_W-1:0] uf_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            uf_cnt_q <= '0;
        end else if (pix_starve && (uf_cnt_q != {UF_CNT_W{1'b1}})) begin
            uf_cnt_q <= uf_cnt_q + 1'b1;
        end
    end

    assign underflow_cnt = uf_cnt_q;
`else
    assign underflow_cnt = '0;
`endif

    logic unused_full;
    assign unused_full = fifo_full;

endmodule
